// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: word width, reset/bubble encodings,
// instruction memory depth, a few opcodes and a target alignment helper.
package mips_pkg;

  localparam int          WORD_W     = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          IMEM_WORDS = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;  // sll $0,$0,0

  localparam logic [5:0]  OP_J       = 6'h02;
  localparam logic [5:0]  OP_BEQ     = 6'h04;

  // Redirect targets are byte addresses; fetch is word-granular, so the
  // two low bits are dropped before they reach the PC.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction memory port: the fetch stage drives a byte address and the
// memory returns the addressed word combinationally.
interface if_stage_if;
  import mips_pkg::*;

  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_instr;

  modport master (output imem_addr, input  imem_instr);
  modport slave  (input  imem_addr, output imem_instr);
endinterface

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register: holds when disabled, loads a bubble on flush,
// otherwise captures the fetched instruction, its PC+4 and validity.
module ifid_reg
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP = NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic [WORD_W-1:0] instr_in,
  input  logic [WORD_W-1:0] pc4_in,
  input  logic              valid_in,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc4,
  output logic              valid
);

  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc4_q,   pc4_d;
  logic              valid_q, valid_d;

  // Next-state selection: hold, flush to bubble, or load.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (en) begin
      if (flush) begin
        instr_d = NOP;
        pc4_d   = '0;
        valid_d = 1'b0;
      end else begin
        instr_d = instr_in;
        pc4_d   = pc4_in;
        valid_d = valid_in;
      end
    end
  end

  // Register update with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of block evaluation order.
    if (reset) begin
      instr_q <= NOP;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (stall > jump >
// branch > sequential), instruction memory range check, IF/ID register and
// a running count of valid instructions delivered to ID.
module if_stage #(
  parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
  parameter int unsigned IMEM_WORDS = mips_pkg::IMEM_WORDS,
  parameter logic [31:0] NOP_INSTR  = mips_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              jump,
  input  logic [31:0]       jump_target,
  if_stage_if.master        imem,
  output logic [31:0]       pc,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc4,
  output logic              ifid_valid,
  output logic [31:0]       fetch_count
);
  import mips_pkg::word_align;

  // One bit wider than the PC so the end-of-memory bound cannot overflow.
  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        in_range;
  logic [31:0] fetched;

  assign pc_plus4 = pc_q + 32'd4;  // wraps modulo 2^32
  assign redirect = jump | branch_taken;
  assign in_range = {1'b0, pc_q} < IMEM_BYTES;
  // Past the end of memory the returned word is meaningless; feed a bubble.
  assign fetched  = in_range ? imem.imem_instr : NOP_INSTR;

  // Next PC and fetch count; jump outranks branch if ID ever raises both.
  always_comb begin
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    if (!stall) begin
      if (jump) begin
        pc_d = word_align(jump_target);
      end else if (branch_taken) begin
        pc_d = word_align(branch_target);
      end else begin
        pc_d = pc_plus4;
        if (in_range) fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  // PC and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  ifid_reg #(.NOP(NOP_INSTR)) u_ifid_reg (
    .clk      (clk),
    .reset    (reset),
    .en       (!stall),
    .flush    (redirect),
    .instr_in (fetched),
    .pc4_in   (pc_plus4),
    .valid_in (in_range),
    .instr    (ifid_instr),
    .pc4      (ifid_pc4),
    .valid    (ifid_valid)
  );

  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign fetch_count    = fetch_count_q;

endmodule
